// File: rtl/neuraedge_noc_packetizer_if.sv
`default_nettype none
// neuraedge_noc_packetizer_if: command, payload and flit-link signals of the tile injection endpoint.
// master = packetizer side, slave = command/data producer plus router local port.
interface neuraedge_noc_packetizer_if #(
    parameter int NOC_FLIT_WIDTH = 64,
    parameter int DATA_W         = 32,
    parameter int COORD_W        = 4,
    parameter int LEN_W          = 8
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [COORD_W-1:0]        cmd_dst_x;
    logic [COORD_W-1:0]        cmd_dst_y;
    logic [LEN_W-1:0]          cmd_len;
    logic                      data_valid;
    logic                      data_ready;
    logic [DATA_W-1:0]         data_in;
    logic [NOC_FLIT_WIDTH-1:0] flit_out;
    logic                      valid_out;
    logic                      ready_in;
    logic                      busy;

    modport master (
        input  cmd_valid, cmd_dst_x, cmd_dst_y, cmd_len,
        input  data_valid, data_in,
        input  ready_in,
        output cmd_ready, data_ready, flit_out, valid_out, busy
    );

    modport slave (
        output cmd_valid, cmd_dst_x, cmd_dst_y, cmd_len,
        output data_valid, data_in,
        output ready_in,
        input  cmd_ready, data_ready, flit_out, valid_out, busy
    );
endinterface
`default_nettype wire

// File: rtl/neuraedge_noc_packetizer.sv
`default_nettype none
// neuraedge_noc_packetizer: turns a (dst, len) command plus PE result words into
// HEAD/BODY.../TAIL flits through a single registered valid/ready output stage.
module neuraedge_noc_packetizer #(
    parameter int NOC_FLIT_WIDTH = 64,
    parameter int DATA_W         = 32,
    parameter int COORD_W        = 4,
    parameter int LEN_W          = 8,
    parameter int SRC_X          = 0,
    parameter int SRC_Y          = 0
) (
    input wire clk,
    input wire rst_n,
    neuraedge_noc_packetizer_if.master bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BODY = 1'b1;

    localparam logic [1:0] TYPE_BODY   = 2'b00;
    localparam logic [1:0] TYPE_HEAD   = 2'b01;
    localparam logic [1:0] TYPE_TAIL   = 2'b10;
    localparam logic [1:0] TYPE_SINGLE = 2'b11;

    localparam int HEAD_BITS = 2 + 4*COORD_W + LEN_W;
    localparam int HEAD_PAD  = NOC_FLIT_WIDTH - HEAD_BITS;

    localparam logic [COORD_W-1:0] SRC_X_C = COORD_W'(SRC_X);
    localparam logic [COORD_W-1:0] SRC_Y_C = COORD_W'(SRC_Y);

    logic [0:0]                state_q, state_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic [LEN_W-1:0]          count_q, count_d;
    logic                      valid_q, valid_d;
    logic [NOC_FLIT_WIDTH-1:0] flit_q, flit_d;

    logic                      load_en;
    logic                      cmd_hs;
    logic                      data_hs;
    logic                      last_word;
    logic [HEAD_BITS-1:0]      head_fields;
    logic [NOC_FLIT_WIDTH-1:0] head_flit;
    logic [NOC_FLIT_WIDTH-1:0] body_flit;

    // Output register may only change when empty or being drained this cycle.
    assign load_en = !valid_q || bus.ready_in;

    assign bus.cmd_ready  = rst_n && (state_q == S_IDLE) && load_en;
    assign bus.data_ready = (state_q == S_BODY) && load_en;

    assign cmd_hs    = bus.cmd_valid && bus.cmd_ready;
    assign data_hs   = bus.data_valid && bus.data_ready;
    assign last_word = (count_q == len_q - LEN_W'(1));

    assign head_fields = {(bus.cmd_len == '0) ? TYPE_SINGLE : TYPE_HEAD,
                          bus.cmd_dst_x, bus.cmd_dst_y, SRC_X_C, SRC_Y_C, bus.cmd_len};
    // Shift rather than concatenate a zero pad so a flit exactly HEAD_BITS wide still elaborates.
    assign head_flit = NOC_FLIT_WIDTH'(head_fields) << HEAD_PAD;

    always_comb begin
        body_flit = '0;
        body_flit[NOC_FLIT_WIDTH-1 -: 2] = last_word ? TYPE_TAIL : TYPE_BODY;
        body_flit[DATA_W-1:0]            = bus.data_in;
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        valid_d = valid_q;
        flit_d  = flit_q;
        if (load_en) begin
            valid_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                if (cmd_hs) begin
                    len_d   = bus.cmd_len;
                    count_d = '0;
                    flit_d  = head_flit;
                    valid_d = 1'b1;
                    state_d = (bus.cmd_len != '0) ? S_BODY : S_IDLE;
                end
            end
            S_BODY: begin
                if (data_hs) begin
                    flit_d  = body_flit;
                    valid_d = 1'b1;
                    count_d = count_q + LEN_W'(1);
                    if (last_word) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            flit_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            valid_q <= valid_d;
            flit_q  <= flit_d;
        end
    end

    assign bus.flit_out  = flit_q;
    assign bus.valid_out = valid_q;
    assign bus.busy      = (state_q != S_IDLE) || valid_q;
endmodule
`default_nettype wire

// File: tb/tb_neuraedge_noc_packetizer.sv
`default_nettype none
// tb_neuraedge_noc_packetizer: directed steps with hand-computed flits for a
// 64-bit flit, 4-bit coordinate, 8-bit length configuration at source tile (5,9).
module tb_neuraedge_noc_packetizer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    neuraedge_noc_packetizer_if #(.NOC_FLIT_WIDTH(64), .DATA_W(32), .COORD_W(4), .LEN_W(8)) bus ();

    neuraedge_noc_packetizer #(
        .NOC_FLIT_WIDTH(64), .DATA_W(32), .COORD_W(4), .LEN_W(8), .SRC_X(5), .SRC_Y(9)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] words [0:1023];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        rand_mode = 1'b0;
    logic        ready_force = 1'b0;
    logic        hs_data = 1'b0;

    logic [63:0] got  [0:1023];
    int          gcyc [0:1023];
    int          got_n = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Router/monitor view: a flit counts when valid and ready are both high before the edge.
    always @(negedge clk) begin
        hs_data = bus.data_valid && bus.data_ready;
        if (bus.valid_out && bus.ready_in) begin
            got[got_n]  = bus.flit_out;
            gcyc[got_n] = cyc;
            got_n       = got_n + 1;
        end
    end

    // Payload producer and router ready, updated shortly after each edge.
    always @(posedge clk) begin
        #2;
        if (hs_data && rd_ptr < wr_ptr) rd_ptr = rd_ptr + 1;
        if (rd_ptr < wr_ptr) begin
            bus.data_valid = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.data_in    = words[rd_ptr];
        end else begin
            bus.data_valid = 1'b0;
            bus.data_in    = '0;
        end
        bus.ready_in = rand_mode ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    function automatic logic [63:0] mk_head(input logic [3:0] dx, input logic [3:0] dy, input logic [7:0] ln);
        logic [63:0] f;
        f        = '0;
        f[63:62] = (ln == 8'd0) ? 2'b11 : 2'b01;
        f[61:58] = dx;
        f[57:54] = dy;
        f[53:50] = 4'd5;
        f[49:46] = 4'd9;
        f[45:38] = ln;
        return f;
    endfunction

    function automatic logic [63:0] mk_body(input logic [31:0] d, input bit last);
        logic [63:0] f;
        f        = '0;
        f[63:62] = last ? 2'b10 : 2'b00;
        f[31:0]  = d;
        return f;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d);
        words[wr_ptr] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic send_cmd(input logic [3:0] dx, input logic [3:0] dy, input logic [7:0] ln, input bit keep);
        int k;
        bus.cmd_valid = 1'b1;
        bus.cmd_dst_x = dx;
        bus.cmd_dst_y = dy;
        bus.cmd_len   = ln;
        k = 0;
        do begin
            @(negedge clk);
            k = k + 1;
        end while (!bus.cmd_ready && k < 200);
        chk("cmd_accept_timeout", 64'(k < 200), 64'd1);
        @(posedge clk); #1;
        if (!keep) bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k = k + 1;
        end while ((bus.busy || rd_ptr != wr_ptr) && k < budget);
        chk(tag, 64'(k < budget), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int start;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_dst_x = '0;
        bus.cmd_dst_y = '0;
        bus.cmd_len   = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid_out",  64'(bus.valid_out),  64'd0);
        chk("rst_flit_out",   bus.flit_out,        64'd0);
        chk("rst_busy",       64'(bus.busy),       64'd0);
        chk("rst_cmd_ready",  64'(bus.cmd_ready),  64'd0);
        chk("rst_data_ready", 64'(bus.data_ready), 64'd0);
        @(posedge clk); #1;
        rst_n       = 1'b1;
        ready_force = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);

        // Basic 2-word packet; words wait unconsumed while idle.
        @(posedge clk); #1;
        base = got_n;
        push(32'hA);
        push(32'hB);
        @(negedge clk);
        chk("idle_data_valid",   64'(bus.data_valid), 64'd1);
        chk("idle_data_ignored", 64'(bus.data_ready), 64'd0);
        @(posedge clk); #1;
        send_cmd(4'd3, 4'd2, 8'd2, 1'b0);
        wait_idle(40, "a_timeout");
        chk("a_count", 64'(got_n - base), 64'd3);
        chk("a_head",  got[base],         mk_head(4'd3, 4'd2, 8'd2));
        chk("a_body",  got[base+1],       mk_body(32'hA, 1'b0));
        chk("a_tail",  got[base+2],       mk_body(32'hB, 1'b1));
        chk("a_span",  64'(gcyc[base+2] - gcyc[base]), 64'd2);

        // Head-only packet; a pending word must stay untouched.
        @(posedge clk); #1;
        base = got_n;
        push(32'h55);
        send_cmd(4'd1, 4'd1, 8'd0, 1'b0);
        @(negedge clk);
        chk("b_valid",      64'(bus.valid_out),  64'd1);
        chk("b_single",     bus.flit_out,        mk_head(4'd1, 4'd1, 8'd0));
        chk("b_cmd_ready",  64'(bus.cmd_ready),  64'd1);
        chk("b_data_ready", 64'(bus.data_ready), 64'd0);
        @(negedge clk);
        chk("b_data_ready2", 64'(bus.data_ready),  64'd0);
        chk("b_busy_done",   64'(bus.busy),        64'd0);
        chk("b_word_kept",   64'(wr_ptr - rd_ptr), 64'd1);
        chk("b_count",       64'(got_n - base),    64'd1);
        @(posedge clk); #1;
        wr_ptr = rd_ptr;

        // Router stall for 5 cycles while the head is held.
        @(posedge clk); #1;
        base = got_n;
        push(32'h11);
        push(32'h22);
        push(32'h33);
        send_cmd(4'd5, 4'd6, 8'd3, 1'b0);
        ready_force = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("c_stall_valid", 64'(bus.valid_out),  64'd1);
            chk("c_stall_flit",  bus.flit_out,        mk_head(4'd5, 4'd6, 8'd3));
            chk("c_stall_dready", 64'(bus.data_ready), 64'd0);
        end
        @(posedge clk); #1;
        ready_force = 1'b1;
        wait_idle(40, "c_timeout");
        chk("c_count", 64'(got_n - base), 64'd4);
        chk("c_head",  got[base],   mk_head(4'd5, 4'd6, 8'd3));
        chk("c_b0",    got[base+1], mk_body(32'h11, 1'b0));
        chk("c_b1",    got[base+2], mk_body(32'h22, 1'b0));
        chk("c_tail",  got[base+3], mk_body(32'h33, 1'b1));

        // Back-to-back commands: head of packet 2 right behind tail of packet 1.
        @(posedge clk); #1;
        base = got_n;
        push(32'h77);
        push(32'h88);
        send_cmd(4'd2, 4'd3, 8'd1, 1'b1);
        send_cmd(4'd4, 4'd4, 8'd1, 1'b0);
        wait_idle(40, "d_timeout");
        chk("d_count", 64'(got_n - base), 64'd4);
        chk("d_head1", got[base],   mk_head(4'd2, 4'd3, 8'd1));
        chk("d_tail1", got[base+1], mk_body(32'h77, 1'b1));
        chk("d_head2", got[base+2], mk_head(4'd4, 4'd4, 8'd1));
        chk("d_tail2", got[base+3], mk_body(32'h88, 1'b1));
        chk("d_span",  64'(gcyc[base+3] - gcyc[base]), 64'd3);

        // Maximum length with random producer and router gaps.
        @(posedge clk); #1;
        base  = got_n;
        start = wr_ptr;
        rand_mode = 1'b1;
        for (int i = 0; i < 255; i++) push($urandom);
        send_cmd(4'd7, 4'd1, 8'd255, 1'b0);
        wait_idle(4000, "e_timeout");
        rand_mode = 1'b0;
        chk("e_count", 64'(got_n - base), 64'd256);
        chk("e_head",  got[base], mk_head(4'd7, 4'd1, 8'd255));
        for (int i = 0; i < 255; i++) begin
            chk("e_payload", got[base+1+i], mk_body(words[start+i], i == 254));
        end

        // Async reset with a packet left open (producer ran dry).
        @(posedge clk); #1;
        base = got_n;
        push(32'h1);
        push(32'h2);
        send_cmd(4'd1, 4'd2, 8'd4, 1'b0);
        repeat (6) @(negedge clk);
        chk("f_open_busy",   64'(bus.busy),       64'd1);
        chk("f_open_valid",  64'(bus.valid_out),  64'd0);
        chk("f_open_dready", 64'(bus.data_ready), 64'd1);
        chk("f_open_count",  64'(got_n - base),   64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("f_rst_valid",  64'(bus.valid_out),  64'd0);
        chk("f_rst_busy",   64'(bus.busy),       64'd0);
        chk("f_rst_flit",   bus.flit_out,        64'd0);
        chk("f_rst_dready", 64'(bus.data_ready), 64'd0);
        chk("f_rst_cready", 64'(bus.cmd_ready),  64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        wr_ptr = rd_ptr;
        base   = got_n;
        push(32'h99);
        send_cmd(4'd3, 4'd3, 8'd1, 1'b0);
        wait_idle(40, "f_timeout");
        chk("f_count", 64'(got_n - base), 64'd2);
        chk("f_head",  got[base],   mk_head(4'd3, 4'd3, 8'd1));
        chk("f_tail",  got[base+1], mk_body(32'h99, 1'b1));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
